// File: rtl/planificador_rr_vc_if.sv
// Bus between the VC scheduler and its input/output FIFOs.
// master = scheduler side, slave = FIFO side.
interface planificador_rr_vc_if #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 4
);
  logic [3:0]          in_empty;
  logic [4*DATA_W-1:0] in_data;
  logic [4*DEST_W-1:0] in_dest;
  logic [3:0]          in_pop;
  logic [3:0]          out_almost_full;
  logic [3:0]          out_push;
  logic [DATA_W-1:0]   out_data;
  logic [DEST_W-1:0]   out_dest;

  modport master (
    input  in_empty, in_data, in_dest, out_almost_full,
    output in_pop, out_push, out_data, out_dest
  );

  modport slave (
    output in_empty, in_data, in_dest, out_almost_full,
    input  in_pop, out_push, out_data, out_dest
  );
endinterface

// File: rtl/planificador_rr_vc.sv
// Round-robin scheduler from 4 show-ahead input FIFOs to 4 output FIFOs,
// with a bounded burst per owner and 1-cycle pop-to-push latency.
module planificador_rr_vc #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 4,
  parameter int BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  enable,
  output logic                  busy,
  planificador_rr_vc_if.master  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [1:0]        owner;
  logic [1:0]        rr_ptr;
  logic [3:0]        burst_cnt;

  logic [DATA_W-1:0] data_arr [4];
  logic [DEST_W-1:0] dest_arr [4];
  logic [3:0]        req;
  logic              cont;
  logic              gnt_valid;
  logic [1:0]        gnt_idx;
  logic [1:0]        idx;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      data_arr[i] = bus.in_data[i*DATA_W +: DATA_W];
      dest_arr[i] = bus.in_dest[i*DEST_W +: DEST_W];
      req[i]      = !bus.in_empty[i] && !bus.out_almost_full[dest_arr[i][1:0]] && enable;
    end
  end

  // Rotation scans the three other inputs first; the owner only keeps the
  // grant (with a fresh burst) when nobody else is requesting.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    cont      = (state == GRANT) && req[owner] && (burst_cnt < 4'(BURST));
    if (state == IDLE) begin
      for (int unsigned k = 0; k < 4; k++) begin
        idx = rr_ptr + 2'(k);
        if (req[idx] && !gnt_valid) begin
          gnt_valid = 1'b1;
          gnt_idx   = idx;
        end
      end
    end else if (cont) begin
      gnt_valid = 1'b1;
      gnt_idx   = owner;
    end else begin
      for (int unsigned k = 1; k < 4; k++) begin
        idx = owner + 2'(k);
        if (req[idx] && !gnt_valid) begin
          gnt_valid = 1'b1;
          gnt_idx   = idx;
        end
      end
      if (!gnt_valid && req[owner]) begin
        gnt_valid = 1'b1;
        gnt_idx   = owner;
      end
    end
  end

  assign bus.in_pop = (gnt_valid && reset_L) ? (4'b0001 << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state        <= IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      burst_cnt    <= '0;
      busy         <= 1'b0;
      bus.out_push <= '0;
      bus.out_data <= '0;
      bus.out_dest <= '0;
    end else begin
      bus.out_push <= gnt_valid ? (4'b0001 << dest_arr[gnt_idx][1:0]) : '0;
      if (gnt_valid) begin
        bus.out_data <= data_arr[gnt_idx];
        bus.out_dest <= dest_arr[gnt_idx];
      end
      if (state == GRANT && !cont)
        rr_ptr <= owner + 2'd1;
      if (gnt_valid) begin
        state     <= GRANT;
        busy      <= 1'b1;
        owner     <= gnt_idx;
        burst_cnt <= cont ? burst_cnt + 4'd1 : 4'd1;
      end else begin
        state     <= IDLE;
        busy      <= 1'b0;
      end
    end
  end

endmodule
